// File: rtl/transpose_pp_stage.sv
// transpose_pp_stage
// Double-buffered (ping-pong) row-to-column transpose stage between the two
// 1D transform passes of the 2D DCT-II. Rows of one block are written into
// one bank while the columns of the previous block are read from the other.
// The block size (4, 8, 16 or 32) is chosen per block on its first row.
//
// Optional feature macro: TPS_SHIFT_EN
//   defined   : each stored lane is (x + 2^(SHIFT-1)) >>> SHIFT (W+1-bit math)
//   undefined : samples are stored verbatim, SHIFT is unused
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   a row is offered on in_row
//   in_ready   out  the row is accepted this cycle
//   in_size    in   size code 0:4 1:8 2:16 3:32, sampled on a block's first row
//   in_row     in   MAXN lanes of W bits, lane k at [k*W +: W]
//   out_valid  out  a column is presented on out_col
//   out_ready  in   the consumer accepts the column
//   out_col    out  MAXN lanes of W bits, lanes >= N and idle cycles are zero
//   out_size   out  size code of the block being drained (0 when idle)
//   out_last   out  the presented column is column N-1 of its block
module transpose_pp_stage #(
  parameter int W     = 16,
  parameter int MAXN  = 32,
  parameter int SHIFT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_size,
  input  logic [MAXN*W-1:0] in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAXN*W-1:0] out_col,
  output logic [1:0]        out_size,
  output logic              out_last
);

  localparam int CW = $clog2(MAXN);

  if (SHIFT < 1 || MAXN < 4 || MAXN > 32) begin : g_param_check
    $error("transpose_pp_stage: illegal SHIFT or MAXN");
  end

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t     r_state [2];
  bank_state_t     w_state_nxt [2];
  logic [1:0]      r_size [2];
  logic [1:0]      w_size_nxt [2];
  logic            r_wsel, w_wsel_nxt;
  logic            r_rsel, w_rsel_nxt;
  logic [CW-1:0]   r_row, w_row_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [W-1:0]    r_mem [2][MAXN][MAXN];

  logic            w_in_hs, w_out_hs, w_wr_first;
  logic [1:0]      w_wr_size;
  logic [CW-1:0]   w_wr_row, w_wr_last, w_rd_last;

  // Last row/column index for a size code; truncation only matters when
  // MAXN < 32, where oversized codes collapse onto the largest legal block.
  function automatic logic [CW-1:0] f_last(input logic [1:0] code);
    logic [5:0] v_last;
    case (code)
      2'd0:    v_last = 6'd3;
      2'd1:    v_last = 6'd7;
      2'd2:    v_last = 6'd15;
      default: v_last = 6'd31;
    endcase
    return v_last[CW-1:0];
  endfunction

`ifdef TPS_SHIFT_EN
  localparam logic [W:0] ROUND = (W+1)'(1) << (SHIFT - 1);

  // Inter-stage rounding shift, one guard bit so +max cannot wrap.
  function automatic logic [W-1:0] f_store(input logic [W-1:0] x);
    logic signed [W:0] v_sum;
    v_sum = $signed({x[W-1], x} + ROUND);
    return W'(v_sum >>> SHIFT);
  endfunction
`else
  function automatic logic [W-1:0] f_store(input logic [W-1:0] x);
    return x;
  endfunction
`endif

  assign in_ready   = (r_state[r_wsel] == ST_EMPTY) || (r_state[r_wsel] == ST_FILLING);
  assign out_valid  = (r_state[r_rsel] == ST_FULL) || (r_state[r_rsel] == ST_DRAINING);
  assign w_in_hs    = in_valid & in_ready;
  assign w_out_hs   = out_valid & out_ready;
  // The first row of a block uses the live size and row 0, not stale bank data.
  assign w_wr_first = (r_state[r_wsel] == ST_EMPTY);
  assign w_wr_size  = w_wr_first ? in_size : r_size[r_wsel];
  assign w_wr_row   = w_wr_first ? {CW{1'b0}} : r_row;
  assign w_wr_last  = f_last(w_wr_size);
  assign w_rd_last  = f_last(r_size[r_rsel]);
  assign out_last   = out_valid & (r_col == w_rd_last);
  assign out_size   = out_valid ? r_size[r_rsel] : 2'd0;

  // Column read mux: lane k of column c is bank[k][c], zero beyond N or when idle.
  always_comb begin
    out_col = {(MAXN*W){1'b0}};
    for (int k = 0; k < MAXN; k++) begin
      if (out_valid && (k <= int'(w_rd_last))) begin
        out_col[k*W +: W] = r_mem[r_rsel][k][r_col];
      end else begin
        out_col[k*W +: W] = {W{1'b0}};
      end
    end
  end

  // Bank state, pointer and counter next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_size_nxt  = r_size;
    w_wsel_nxt  = r_wsel;
    w_rsel_nxt  = r_rsel;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    if (w_in_hs) begin
      w_size_nxt[r_wsel] = w_wr_size;
      if (w_wr_row == w_wr_last) begin
        w_state_nxt[r_wsel] = ST_FULL;
        w_wsel_nxt          = ~r_wsel;
        w_row_nxt           = {CW{1'b0}};
      end else begin
        w_state_nxt[r_wsel] = ST_FILLING;
        w_row_nxt           = w_wr_row + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      w_row_nxt = r_row;
    end
    // Write and read banks always differ while both are active, so these
    // two updates never touch the same bank entry.
    if (w_out_hs) begin
      if (out_last) begin
        w_state_nxt[r_rsel] = ST_EMPTY;
        w_rsel_nxt          = ~r_rsel;
        w_col_nxt           = {CW{1'b0}};
      end else begin
        w_state_nxt[r_rsel] = ST_DRAINING;
        w_col_nxt           = r_col + {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (out_valid) begin
      w_state_nxt[r_rsel] = ST_DRAINING;
    end else begin
      w_col_nxt = r_col;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
      r_size[0]  <= 2'd0;
      r_size[1]  <= 2'd0;
      r_wsel     <= 1'b0;
      r_rsel     <= 1'b0;
      r_row      <= {CW{1'b0}};
      r_col      <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_size  <= w_size_nxt;
      r_wsel  <= w_wsel_nxt;
      r_rsel  <= w_rsel_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Sample storage: no reset, only lanes below N of an accepted row are written.
  always_ff @(posedge clk) begin
    if (w_in_hs && !reset) begin
      for (int k = 0; k < MAXN; k++) begin
        if (k <= int'(w_wr_last)) begin
          r_mem[r_wsel][w_wr_row][k] <= f_store(in_row[k*W +: W]);
        end
      end
    end
  end

endmodule
